// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: a per-register countdown scoreboard that stalls RAW
// dependents until their source can be read safely, with optional forwarding.
module hazard_scoreboard #(
  parameter int NUM_REGS     = 8,
  parameter int REG_W        = $clog2(NUM_REGS),
  parameter int PIPE_DEPTH   = 3,
  parameter int FWD_EN       = 0,
  parameter int LOAD_USE_LAT = 1,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                id_rd_wr,
  input  logic                id_is_load,
  input  logic                stat_clr,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int CW       = $clog2(PIPE_DEPTH);
  localparam int PAD_REGS = 1 << REG_W;
  localparam logic [CW-1:0]    NO_FWD_LOAD   = CW'(PIPE_DEPTH - 1);
  localparam logic [CW-1:0]    LOAD_USE_LOAD = CW'(LOAD_USE_LAT);
  localparam logic [CW-1:0]    CNT_ONE       = CW'(1'b1);
  localparam logic [CNT_W-1:0] STAT_ONE      = CNT_W'(1'b1);

  logic [CW-1:0]       cnt     [NUM_REGS];
  logic [CW-1:0]       cntNext [NUM_REGS];
  logic [NUM_REGS-1:0] busyNext;
  logic [PAD_REGS-1:0] pending;
  logic                rsHazard;
  logic                rtHazard;
  logic                issue;
  logic [CW-1:0]       loadVal;

  // Pending-write view of the counters, padded so every encodable index is safe
  always_comb begin
    pending = {PAD_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      pending[i] = (cnt[i] != {CW{1'b0}});
    end
  end

  // Hazard detection and issue decision
  always_comb begin
    rsHazard = id_rs_used & pending[id_rs];
    rtHazard = id_rt_used & pending[id_rt];
    stall    = id_valid & (rsHazard | rtHazard) & ~hold;
    issue    = id_valid & ~stall & ~hold;
  end

  // Countdown loaded for the destination of an issuing writer
  always_comb begin
    if (FWD_EN != 0) begin
      if (id_is_load) begin
        loadVal = LOAD_USE_LOAD;
      end else begin
        loadVal = {CW{1'b0}};
      end
    end else begin
      loadVal = NO_FWD_LOAD;
    end
  end

  // Next counter state: the newest writer reloads, every other counter drains
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cntNext[i] = cnt[i];
      if (issue & id_rd_wr & (id_rd == REG_W'(i))) begin
        cntNext[i] = loadVal;
      end else if (cnt[i] != {CW{1'b0}}) begin
        cntNext[i] = cnt[i] - CNT_ONE;
      end else begin
        cntNext[i] = cnt[i];
      end
      busyNext[i] = (cntNext[i] != {CW{1'b0}});
    end
  end

  // Scoreboard registers; a pipeline freeze holds everything in place
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt[i] <= {CW{1'b0}};
      end
      busy <= {NUM_REGS{1'b0}};
    end else if (!hold) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt[i] <= cntNext[i];
      end
      busy <= busyNext;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt[i] <= cnt[i];
      end
      busy <= busy;
    end
  end

  // Saturating stall statistics; clear wins over a same-cycle stall
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (hold) begin
      stall_cnt <= stall_cnt;
    end else if (stat_clr) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (stall && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + STAT_ONE;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a no-forwarding and a forwarding instance share
// stimulus and are checked against a ready-time reference model.
module tb_hazard_scoreboard;

  localparam int NR = 8;

  logic       clk = 1'b0;
  logic       rst, hold, id_valid, id_rs_used, id_rt_used, id_rd_wr, id_is_load, stat_clr;
  logic [2:0] id_rs, id_rt, id_rd;
  logic       stall0, stall1;
  logic [7:0] busy0, busy1;
  logic [3:0] cnt0;
  logic [15:0] cnt1;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_REGS(8), .PIPE_DEPTH(3), .FWD_EN(0), .LOAD_USE_LAT(1), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .hold(hold), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_rd_wr(id_rd_wr),
    .id_is_load(id_is_load), .stat_clr(stat_clr), .stall(stall0), .busy(busy0), .stall_cnt(cnt0));

  hazard_scoreboard #(.NUM_REGS(8), .PIPE_DEPTH(3), .FWD_EN(1), .LOAD_USE_LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .hold(hold), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_rd_wr(id_rd_wr),
    .id_is_load(id_is_load), .stat_clr(stat_clr), .stall(stall1), .busy(busy1), .stall_cnt(cnt1));

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: each register records the advancing-cycle number from which
  // a reader may issue; frozen cycles do not advance the model's time.
  longint readyAt [2][NR];
  longint nowCyc  [2];
  longint statCnt [2];

  logic       lastStall0, lastStall1;
  logic [7:0] lastBusy0;
  logic [3:0] lastCnt0;
  logic [15:0] lastCnt1;

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    testsRun++;
    if (obs !== expv) begin
      testsFailed++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic logic expStall(input int m);
    logic rsH, rtH;
    rsH = id_rs_used && (readyAt[m][id_rs] > nowCyc[m]);
    rtH = id_rt_used && (readyAt[m][id_rt] > nowCyc[m]);
    return id_valid && (rsH || rtH) && !hold;
  endfunction

  function automatic logic [7:0] expBusy(input int m);
    logic [7:0] b;
    for (int i = 0; i < NR; i++) b[i] = (readyAt[m][i] > nowCyc[m]);
    return b;
  endfunction

  task automatic modelStep(input int m, input logic s);
    longint lv, maxCnt;
    maxCnt = (m == 0) ? 64'd15 : 64'd65535;
    if (m == 0) lv = 2;                     // PIPE_DEPTH-1 without forwarding
    else        lv = id_is_load ? 1 : 0;    // load-use latency with forwarding
    if (rst) begin
      for (int i = 0; i < NR; i++) readyAt[m][i] = 0;
      nowCyc[m]  = 0;
      statCnt[m] = 0;
    end else if (!hold) begin
      if (id_valid && !s && id_rd_wr) readyAt[m][id_rd] = nowCyc[m] + 1 + lv;
      if (stat_clr) statCnt[m] = 0;
      else if (s && statCnt[m] < maxCnt) statCnt[m] = statCnt[m] + 1;
      nowCyc[m] = nowCyc[m] + 1;
    end
  endtask

  // One cycle: inputs are already set at the falling edge
  task automatic tick();
    logic s0, s1;
    #1;
    s0 = expStall(0);
    s1 = expStall(1);
    lastStall0 = stall0; lastStall1 = stall1;
    lastBusy0  = busy0;  lastCnt0   = cnt0; lastCnt1 = cnt1;
    checkValue("stall_nofwd", stall0, s0);
    checkValue("stall_fwd",   stall1, s1);
    checkValue("busy_nofwd",  busy0,  expBusy(0));
    checkValue("busy_fwd",    busy1,  expBusy(1));
    checkValue("cnt_nofwd",   cnt0,   statCnt[0]);
    checkValue("cnt_fwd",     cnt1,   statCnt[1]);
    modelStep(0, s0);
    modelStep(1, s1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setIns(input logic v, input logic [2:0] rs, input logic rsu, input logic [2:0] rt,
                        input logic rtu, input logic [2:0] rd, input logic wr, input logic ld);
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_rd = rd; id_rd_wr = wr; id_is_load = ld;
  endtask

  task automatic drain();
    setIns(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; stat_clr = 1'b0;
    setIns(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NR; i++) readyAt[m][i] = 0;
      nowCyc[m] = 0; statCnt[m] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    setIns(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
    tick();
    checkValue("rst_busy", lastBusy0, 8'h00);
    checkValue("rst_stall", lastStall0, 1'b0);
    checkValue("rst_cnt", lastCnt0, 4'h0);
    drain();

    // Independent stream: distinct writers, no reads
    setIns(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0); tick();
    setIns(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0); tick();
    setIns(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0); tick();
    drain();
    checkValue("indep_cnt", lastCnt0, 4'h0);

    // ADD r1 then SUB r2,r1,r3: two stalls without forwarding
    setIns(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0); tick();
    setIns(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 3'd2, 1'b1, 1'b0);
    tick(); checkValue("raw_stall1", lastStall0, 1'b1); checkValue("raw_busy1", lastBusy0[1], 1'b1);
    tick(); checkValue("raw_stall2", lastStall0, 1'b1); checkValue("raw_busy2", lastBusy0[1], 1'b1);
    tick(); checkValue("raw_issue", lastStall0, 1'b0); checkValue("raw_busy3", lastBusy0[1], 1'b0);
    checkValue("raw_cnt", lastCnt0, 4'h2);
    drain();

    // Forwarding: load-use costs one stall, ALU producer costs none
    setIns(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1); tick();
    setIns(1'b1, 3'd4, 1'b1, 3'd4, 1'b1, 3'd5, 1'b1, 1'b0);
    tick(); checkValue("lu_stall", lastStall1, 1'b1);
    tick(); checkValue("lu_issue", lastStall1, 1'b0);
    tick();
    drain();
    setIns(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0); tick();
    setIns(1'b1, 3'd4, 1'b1, 3'd4, 1'b1, 3'd5, 1'b1, 1'b0);
    tick(); checkValue("alu_fwd", lastStall1, 1'b0);
    drain();

    // Store data register is a real read; unused field and NOP are not
    setIns(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0); tick();
    setIns(1'b1, 3'd2, 1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0);
    tick(); checkValue("store_raw", lastStall0, 1'b1);
    setIns(1'b1, 3'd2, 1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0);
    tick(); checkValue("store_nouse", lastStall0, 1'b0);
    setIns(1'b0, 3'd2, 1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0);
    tick(); checkValue("nop_0800", lastStall0, 1'b0);
    drain();

    // Freeze for four cycles while the counter sits at 1
    setIns(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0); tick();
    setIns(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
    tick(); checkValue("hold_pre", lastStall0, 1'b1);
    hold = 1'b1;
    repeat (4) begin
      tick();
      checkValue("hold_stall", lastStall0, 1'b0);
      checkValue("hold_busy", lastBusy0[5], 1'b1);
    end
    hold = 1'b0;
    tick(); checkValue("hold_resume", lastStall0, 1'b1);
    tick(); checkValue("hold_issue", lastStall0, 1'b0);
    drain();

    // Back-to-back self-dependent chain drives the 4-bit counter into saturation
    setIns(1'b1, 3'd7, 1'b1, 3'd7, 1'b0, 3'd7, 1'b1, 1'b1);
    repeat (45) tick();
    checkValue("sat", lastCnt0, 4'hF);
    drain();

    // Clear takes priority over a stall in the same cycle
    setIns(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0); tick();
    setIns(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    stat_clr = 1'b1;
    tick(); checkValue("clr_stall", lastStall0, 1'b1);
    stat_clr = 1'b0;
    tick(); checkValue("clr_prio", lastCnt0, 4'h0);
    drain();

    // Reset in the middle of a stall releases it on the next cycle
    setIns(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0); tick();
    setIns(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
    tick(); checkValue("rstmid_pre", lastStall0, 1'b1);
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    checkValue("rstmid_stall", lastStall0, 1'b0);
    checkValue("rstmid_busy", lastBusy0, 8'h00);

    // Randomized traffic biased towards a few registers to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 99) == 0);
      hold     = ($urandom_range(0, 7) == 0);
      stat_clr = ($urandom_range(0, 31) == 0);
      setIns(($urandom_range(0, 3) != 0),
             3'($urandom_range(0, 3) + (($urandom_range(0, 3) == 0) ? 4 : 0)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 3) + (($urandom_range(0, 3) == 0) ? 4 : 0)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end

    rst = 1'b0; hold = 1'b0; stat_clr = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
